// File: rtl/fpu_pkg.sv
// Shared constants for the FPU issue/execute slice: multiplier widths,
// step count and controller state encodings.
package fpu_pkg;

   localparam int MUL_W     = 32;
   localparam int PROD_W    = 64;
   localparam int MUL_STEPS = 32;
   localparam int CNT_W     = $clog2(MUL_STEPS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Unsigned magnitude of an operand; 0x80000000 maps to itself.
   function automatic logic [MUL_W-1:0] op_magnitude(input logic [MUL_W-1:0] v,
                                                     input logic            sgn);
      return (sgn && v[MUL_W-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mul_step_dp.sv
// Shift-add datapath: operand magnitudes, 64-bit accumulator, log shifter
// and the gated addend feeding a single shared adder.
module mul_step_dp
   import fpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [CNT_W-1:0]  cnt,
   input  logic [MUL_W-1:0]  op_a,
   input  logic [MUL_W-1:0]  op_b,
   input  logic              is_signed,
   output logic [PROD_W-1:0] acc,
   output logic              neg
);

   logic [MUL_W-1:0]  ma_reg, ma_next;
   logic [MUL_W-1:0]  mb_reg, mb_next;
   logic [PROD_W-1:0] acc_reg, acc_next;
   logic              neg_reg, neg_next;

   logic [PROD_W-1:0] shift_base;
   logic [PROD_W-1:0] shifted;
   logic [PROD_W-1:0] addend;
   logic [PROD_W-1:0] sum;

   assign shift_base = {{(PROD_W-MUL_W){1'b0}}, ma_reg};

   // Logarithmic shifter: stage gi moves the magnitude by 2**gi when cnt[gi] is set.
   genvar gi;
   generate
      for (gi = 0; gi < CNT_W; gi++) begin : g_shift
         logic [PROD_W-1:0] stage_in;
         logic [PROD_W-1:0] stage_out;
         if (gi == 0) begin : g_first
            assign stage_in = shift_base;
         end else begin : g_rest
            assign stage_in = g_shift[gi-1].stage_out;
         end
         assign stage_out = cnt[gi] ? (stage_in << (2**gi)) : stage_in;
      end
   endgenerate

   assign shifted = g_shift[CNT_W-1].stage_out;
   assign addend  = mb_reg[cnt] ? shifted : '0;
   assign sum     = acc_reg + addend;

   always_comb begin
      ma_next  = ma_reg;
      mb_next  = mb_reg;
      acc_next = acc_reg;
      neg_next = neg_reg;
      if (load) begin
         ma_next  = op_magnitude(op_a, is_signed);
         mb_next  = op_magnitude(op_b, is_signed);
         neg_next = is_signed && (op_a[MUL_W-1] ^ op_b[MUL_W-1]);
         acc_next = '0;
      end else if (step) begin
         acc_next = sum;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ma_reg  <= '0;
         mb_reg  <= '0;
         acc_reg <= '0;
         neg_reg <= 1'b0;
      end else begin
         ma_reg  <= ma_next;
         mb_reg  <= mb_next;
         acc_reg <= acc_next;
         neg_reg <= neg_next;
      end
   end

   assign acc = acc_reg;
   assign neg = neg_reg;

endmodule

// File: rtl/seq_mul32.sv
// Sequential 32x32->64 multiplier controller: handshake, step counter and
// sign fix-up around the shared shift-add datapath.
module seq_mul32
   import fpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MUL_W-1:0]  op_a,
   input  logic [MUL_W-1:0]  op_b,
   input  logic              is_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy
);

   logic [1:0]        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [PROD_W-1:0] product_reg, product_next;

   logic              dp_load;
   logic              dp_step;
   logic [PROD_W-1:0] dp_acc;
   logic              dp_neg;

   assign dp_load = in_valid && (state_reg == ST_IDLE);
   assign dp_step = (state_reg == ST_RUN);

   mul_step_dp u_dp (
      .clk       (clk),
      .reset     (reset),
      .load      (dp_load),
      .step      (dp_step),
      .cnt       (cnt_reg),
      .op_a      (op_a),
      .op_b      (op_b),
      .is_signed (is_signed),
      .acc       (dp_acc),
      .neg       (dp_neg)
   );

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;
      case (state_reg)
         ST_IDLE: begin
            if (in_valid) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         end
         ST_RUN: begin
            // Counter wraps to zero on the last step, ready for the next operation.
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(MUL_STEPS-1)) begin
               state_next = ST_FIX;
            end
         end
         ST_FIX: begin
            product_next = dp_neg ? (~dp_acc + 1'b1) : dp_acc;
            state_next   = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         product_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
      end
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign busy      = (state_reg == ST_RUN) || (state_reg == ST_FIX);
   assign product   = product_reg;

endmodule

// File: tb/tb_seq_mul32.sv
// Directed self-checking bench for seq_mul32: products, latency,
// backpressure, mid-run reset and back-to-back issue.
module tb_seq_mul32;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   int checks = 0;
   int errors = 0;

   seq_mul32 dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one operand pair; returns at the negedge after the accepting edge.
   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      check("in_ready_before_accept", in_ready, 1);
      op_a      = a;
      op_b      = b;
      is_signed = s;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("in_ready_after_accept", in_ready, 0);
   endtask

   // Edges after the accepting edge until out_valid is seen (bounded).
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 60);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_after_take", in_ready, 1);
      check("out_valid_after_take", out_valid, 0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp);
      int n;
      start(a, b, s);
      wait_done(n);
      // out_valid appears 33 edges after the accepting edge (34 cycles incl. accept cycle).
      check({tag, "_latency"}, 64'(n), 64'd33);
      check({tag, "_product"}, product, exp);
      check({tag, "_busy_done"}, busy, 0);
      $display("op %s a=%h b=%h signed=%0d product=%h latency=%0d", tag, a, b, s, product, n);
      take();
   endtask

   initial begin
      int n;
      int k;
      int acc_n;
      int res_n;
      int acc_e[2];
      logic [63:0] res_p[2];
      logic [63:0] held;

      reset     = 1'b1;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      is_signed = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_product", product, 0);
      reset = 1'b0;

      run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      run_op("smix", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("umix", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
      run_op("smin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      run_op("sneg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1);

      // Backpressure: hold DONE while new operands are offered.
      start(32'h0000_1234, 32'h0000_0010, 1'b0);
      wait_done(n);
      check("bp_latency", 64'(n), 64'd33);
      held = product;
      check("bp_product", held, 64'h0000_0000_0001_2340);
      for (int i = 0; i < 10; i++) begin
         in_valid  = i[0];
         op_a      = 32'hDEAD_0000 + 32'(i);
         op_b      = 32'h0000_0003;
         is_signed = 1'b1;
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_product_stable", product, 64'h0000_0000_0001_2340);
         check("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      $display("op bp product=%h held 10 cycles", product);
      take();

      // Reset ten edges into a 7x9 operation.
      start(32'd7, 32'd9, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_in_ready", in_ready, 1);
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_product", product, 0);
      $display("op reset mid-run in_ready=%0d busy=%0d product=%h", in_ready, busy, product);
      run_op("after_rst", 32'd3, 32'd4, 1'b0, 64'hC);

      // Back-to-back with out_ready tied high.
      out_ready = 1'b1;
      @(negedge clk);
      op_a      = 32'd1000;
      op_b      = 32'd2000;
      is_signed = 1'b0;
      in_valid  = 1'b1;
      k     = 0;
      acc_n = 0;
      res_n = 0;
      acc_e[0] = 0;
      acc_e[1] = 0;
      res_p[0] = '0;
      res_p[1] = '0;
      while (res_n < 2 && k < 200) begin
         if (in_ready && in_valid && acc_n < 2) begin
            acc_e[acc_n] = k + 1;
            acc_n++;
         end
         if (out_valid) begin
            res_p[res_n] = product;
            res_n++;
         end
         @(negedge clk);
         k++;
         if (acc_n == 1) begin
            op_a      = 32'hFFFF_FFF9;
            op_b      = 32'd6;
            is_signed = 1'b1;
         end
         if (acc_n == 2) in_valid = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_results_seen", 64'(res_n), 64'd2);
      check("b2b_interval", 64'(acc_e[1] - acc_e[0]), 64'd35);
      check("b2b_product0", res_p[0], 64'h0000_0000_001E_8480);
      check("b2b_product1", res_p[1], 64'hFFFF_FFFF_FFFF_FFD6);
      $display("op b2b accepts at %0d and %0d products %h %h", acc_e[0], acc_e[1], res_p[0], res_p[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
